// File: rtl/ahb_lite_sram_slave.sv
// ahb_lite_sram_slave: AHB-Lite word memory slave with programmable wait states.
module ahb_lite_sram_slave #(
  parameter int ADDR_WIDTH  = 32,
  parameter int DATA_WIDTH  = 32,
  parameter int DEPTH       = 256,
  parameter int WAIT_STATES = 2
) (
  input  logic                  HCLK,
  input  logic                  HRESETn,
  input  logic                  HSEL,
  input  logic [ADDR_WIDTH-1:0] HADDR,
  input  logic                  HWRITE,
  input  logic [DATA_WIDTH-1:0] HWDATA,
  output logic [DATA_WIDTH-1:0] HRDATA,
  output logic                  HREADY
);
  localparam int AW = $clog2(DEPTH);
  typedef enum logic {IDLE, DATA} state_t;
  state_t                  state, state_d;
  logic [AW-1:0]           addr_q;
  logic                    write_q;
  logic [3:0]              cnt;
  logic [DATA_WIDTH-1:0]   mem [DEPTH];
  logic                    accept, commit;
  logic                    unused_addr;
  assign unused_addr = ^{HADDR[ADDR_WIDTH-1:AW+2], HADDR[1:0]};
  assign accept = HSEL && HREADY;
  assign commit = (state == DATA) && HREADY;
  always_ff @(posedge HCLK or negedge HRESETn)
    if (!HRESETn) begin
      state   <= IDLE;
      cnt     <= '0;
      addr_q  <= '0;
      write_q <= 1'b0;
    end else begin
      state <= state_d;
      if (accept) begin
        addr_q  <= HADDR[AW+1:2];
        write_q <= HWRITE;
      end
      cnt <= accept ? 4'(WAIT_STATES) : (cnt != 4'd0 ? cnt - 4'd1 : cnt);
    end
  always_comb
    state_d = accept ? DATA : ((state == DATA) && !HREADY) ? DATA : IDLE;
  always_comb begin
    HREADY = (state == IDLE) || (cnt == 4'd0);
    HRDATA = ((state == DATA) && !write_q) ? mem[addr_q] : '0;
  end
  // Memory is deliberately unreset; a write in flight at reset never reaches commit.
  always_ff @(posedge HCLK)
    if (commit && write_q) mem[addr_q] <= HWDATA;
endmodule
